// File: rtl/mem_stream_port_pkg.sv
// Shared definitions for the host stream port: FSM state encoding and default widths.
package mem_stream_port_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DUMP = 2'd3
    } state_t;

    localparam int unsigned DEF_DATA_W = 16;
    localparam int unsigned DEF_ADDR_W = 8;

endpackage

// File: rtl/mem_stream_port_skid.sv
// Two-entry valid/ready buffer; the producer only pushes when it has reserved room.
module stream_skid #(
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [1:0]        count
);
    logic [DATA_W-1:0] buf_q [2];
    logic              rd_ptr_q, rd_ptr_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic [1:0]        count_q, count_d;
    logic              pop;

    assign out_valid = (count_q != 2'd0);
    assign out_data  = out_valid ? buf_q[rd_ptr_q] : '0;
    assign pop       = out_valid && out_ready;
    assign count     = count_q;

    always_comb begin
        rd_ptr_d = rd_ptr_q ^ pop;
        wr_ptr_d = wr_ptr_q ^ in_valid;
        count_d  = count_q + {1'b0, in_valid} - {1'b0, pop};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= '0;
            for (int unsigned i = 0; i < 2; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            if (in_valid) begin
                buf_q[wr_ptr_q] <= in_data;
            end
        end
    end

endmodule

// File: rtl/mem_stream_port.sv
// Host stream port: loads a word stream into data memory, starts the cores,
// waits for completion, then streams a memory window back out.
module mem_stream_port
    import mem_stream_port_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              core_start,
    input  logic              core_done,
    input  logic [ADDR_W-1:0] dump_base,
    input  logic [ADDR_W:0]   dump_len,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              out_last,
    input  logic              out_ready,
    output logic [1:0]        state,
    output logic              session_done,
    output logic              load_overflow
);
    state_t            state_q, state_d;
    logic [ADDR_W:0]   wr_cnt_q, wr_cnt_d;
    logic              ovf_q, ovf_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              core_start_q, core_start_d;
    logic              done_q, done_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_W:0]   rd_rem_q, rd_rem_d;
    logic [ADDR_W:0]   out_rem_q, out_rem_d;
    logic              inflight_q, inflight_d;

    logic [1:0]        sk_count;
    logic              accept, pop, issue;
    logic [2:0]        occ;

    stream_skid #(.DATA_W(DATA_W)) u_skid (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (inflight_q),
        .in_data   (mem_rdata),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .count     (sk_count)
    );

    assign in_ready      = (state_q == ST_LOAD);
    assign accept        = in_ready && in_valid;
    assign pop           = out_valid && out_ready;
    assign out_last      = out_valid && (out_rem_q == (ADDR_W+1)'(1));
    assign state         = state_q;
    assign mem_we        = mem_we_q;
    assign mem_wdata     = wdata_q;
    assign core_start    = core_start_q;
    assign session_done  = done_q;
    assign load_overflow = ovf_q;
    // The read address is presented combinationally so the in-flight word is the only
    // one in the memory pipeline; room counts it, net of the pop happening this cycle.
    assign mem_addr      = (state_q == ST_DUMP) ? rd_addr_q : wr_addr_q;
    assign occ           = {1'b0, sk_count} + {2'b0, inflight_q};
    assign issue         = (state_q == ST_DUMP) && (rd_rem_q != '0)
                           && (occ <= ({2'b0, pop} + 3'd1));

    always_comb begin
        state_d      = state_q;
        wr_cnt_d     = wr_cnt_q;
        ovf_d        = ovf_q;
        mem_we_d     = 1'b0;
        wr_addr_d    = wr_addr_q;
        wdata_d      = wdata_q;
        core_start_d = 1'b0;
        done_d       = 1'b0;
        rd_addr_d    = rd_addr_q;
        rd_rem_d     = rd_rem_q;
        out_rem_d    = out_rem_q;
        inflight_d   = issue;
        case (state_q)
            ST_IDLE: begin
                if (load_start) begin
                    state_d  = ST_LOAD;
                    wr_cnt_d = '0;
                    ovf_d    = 1'b0;
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    // The MSB of the counter marks a full memory; words past it are dropped.
                    if (!wr_cnt_q[ADDR_W]) begin
                        mem_we_d  = 1'b1;
                        wr_addr_d = wr_cnt_q[ADDR_W-1:0];
                        wdata_d   = in_data;
                        wr_cnt_d  = wr_cnt_q + (ADDR_W+1)'(1);
                    end else begin
                        ovf_d = 1'b1;
                    end
                    if (in_last) begin
                        state_d      = ST_RUN;
                        core_start_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (core_done) begin
                    state_d   = ST_DUMP;
                    rd_addr_d = dump_base;
                    rd_rem_d  = dump_len;
                    out_rem_d = dump_len;
                end
            end
            ST_DUMP: begin
                if (issue) begin
                    rd_addr_d = rd_addr_q + ADDR_W'(1);
                    rd_rem_d  = rd_rem_q - (ADDR_W+1)'(1);
                end
                if (pop) begin
                    out_rem_d = out_rem_q - (ADDR_W+1)'(1);
                end
                if ((out_rem_q == '0) || (pop && out_last)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            wr_cnt_q     <= '0;
            ovf_q        <= 1'b0;
            mem_we_q     <= 1'b0;
            wr_addr_q    <= '0;
            wdata_q      <= '0;
            core_start_q <= 1'b0;
            done_q       <= 1'b0;
            rd_addr_q    <= '0;
            rd_rem_q     <= '0;
            out_rem_q    <= '0;
            inflight_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_cnt_q     <= wr_cnt_d;
            ovf_q        <= ovf_d;
            mem_we_q     <= mem_we_d;
            wr_addr_q    <= wr_addr_d;
            wdata_q      <= wdata_d;
            core_start_q <= core_start_d;
            done_q       <= done_d;
            rd_addr_q    <= rd_addr_d;
            rd_rem_q     <= rd_rem_d;
            out_rem_q    <= out_rem_d;
            inflight_q   <= inflight_d;
        end
    end

endmodule

// File: tb/tb_mem_stream_port.sv
// Directed + randomized sessions against a reference model of memory contents and dump windows.
module tb_mem_stream_port;
    localparam int DW    = 16;
    localparam int AW    = 3;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          reset, load_start, in_valid, in_last, in_ready;
    logic [DW-1:0] in_data, mem_wdata, mem_rdata, out_data;
    logic          mem_we, core_start, core_done, out_valid, out_last, out_ready;
    logic [AW-1:0] mem_addr, dump_base;
    logic [AW:0]   dump_len;
    logic [1:0]    state;
    logic          session_done, load_overflow;

    always #5 clk = ~clk;

    mem_stream_port #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk           (clk),
        .reset         (reset),
        .load_start    (load_start),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_last       (in_last),
        .in_ready      (in_ready),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .core_start    (core_start),
        .core_done     (core_done),
        .dump_base     (dump_base),
        .dump_len      (dump_len),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_last      (out_last),
        .out_ready     (out_ready),
        .state         (state),
        .session_done  (session_done),
        .load_overflow (load_overflow)
    );

    // Data memory attached to the port: synchronous write, one-cycle read latency.
    logic [DW-1:0] ram [DEPTH];
    int            wr_count = 0;
    always @(posedge clk) begin
        if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
            wr_count      <= wr_count + 1;
        end
        mem_rdata <= ram[mem_addr];
    end

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] words [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_state"}, state, 0);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_mem_we"}, mem_we, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
        chk({tag, "_core_start"}, core_start, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_out_last"}, out_last, 0);
        chk({tag, "_session_done"}, session_done, 0);
        chk({tag, "_load_overflow"}, load_overflow, 0);
    endtask

    task automatic fill_random(input int n);
        words.delete();
        for (int i = 0; i < n; i++) words.push_back(DW'($urandom));
    endtask

    // mode 0: out_ready held high; 1: 1,0,0,1 pattern then random stalls; 2: random.
    task automatic run_session(input int n, input int base, input int len,
                               input int mode, input bit abort);
        logic [DW-1:0] expq [$];
        logic [DW-1:0] prev_data, expv;
        int  wb, d, first, nexp;
        bit  done, prev_stall;
        dump_base = AW'(base);
        dump_len  = (AW+1)'(len);
        wb = wr_count;

        load_start = 1'b1;
        step();
        load_start = 1'b0;
        chk("load_state", state, 1);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                step();
            end
            in_valid = 1'b1;
            in_data  = words[i];
            in_last  = (i == n - 1);
            @(negedge clk);
            chk("in_ready", in_ready, 1);
            step();
            if (i < DEPTH) begin
                chk("wr_we", mem_we, 1);
                chk("wr_addr", mem_addr, i);
                chk("wr_data", mem_wdata, words[i]);
            end else begin
                chk("wr_drop", mem_we, 0);
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("run_state", state, 2);
        chk("core_start", core_start, 1);
        chk("overflow", load_overflow, n > DEPTH);
        for (int i = 0; i < n && i < DEPTH; i++) ref_mem[i] = words[i];

        d = $urandom_range(0, 3);
        for (int k = 0; k < d; k++) begin
            load_start = (k == 0);
            step();
            load_start = 1'b0;
            chk("run_hold", state, 2);
            chk("core_start_pulse", core_start, 0);
        end
        core_done = 1'b1;
        step();
        core_done = 1'b0;

        chk("dump_state", state, 3);
        chk("dump_first_addr", mem_addr, base % DEPTH);
        chk("wr_total", wr_count - wb, (n < DEPTH) ? n : DEPTH);
        for (int i = 0; i < len; i++) expq.push_back(ref_mem[(base + i) % DEPTH]);

        if (len == 0) begin
            @(negedge clk);
            chk("len0_no_valid", out_valid, 0);
            step();
            chk("len0_idle", state, 0);
            chk("len0_done", session_done, 1);
            step();
            chk("len0_done_pulse", session_done, 0);
            return;
        end

        first = -1;
        done = 1'b0;
        prev_stall = 1'b0;
        prev_data = '0;
        for (int c = 0; c < 200 && !done; c++) begin
            case (mode)
                0: out_ready = 1'b1;
                1: out_ready = (c % 4 == 1 || c % 4 == 2) ? 1'b0
                             : ((c >= 8) ? ($urandom_range(0, 2) != 0) : 1'b1);
                default: out_ready = ($urandom_range(0, 1) == 1);
            endcase
            @(negedge clk);
            if (abort && out_valid) begin
                reset = 1'b1;
                step();
                reset = 1'b0;
                chk_reset_outputs("abort");
                return;
            end
            if (prev_stall) begin
                chk("stall_valid_hold", out_valid, 1);
                chk("stall_data_hold", out_data, prev_data);
            end
            if (mode == 0 && first >= 0) chk("no_bubble", out_valid, 1);
            if (out_valid) begin
                if (first < 0) begin
                    first = c;
                    chk("first_valid_latency", c, 2);
                end
                if (out_ready) begin
                    nexp = expq.size();
                    chk("no_extra_word", nexp > 0, 1);
                    if (nexp > 0) begin
                        expv = expq.pop_front();
                        chk("out_data", out_data, expv);
                        chk("out_last", out_last, expq.size() == 0);
                        if (out_last) done = 1'b1;
                    end
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            step();
        end
        out_ready = 1'b0;
        chk("dump_complete", done, 1);
        chk("all_words_seen", expq.size(), 0);
        chk("end_idle", state, 0);
        chk("end_done", session_done, 1);
        chk("end_no_valid", out_valid, 0);
        step();
        chk("end_done_pulse", session_done, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        load_start = 1'b0;
        in_data = '0;
        in_valid = 1'b0;
        in_last = 1'b0;
        core_done = 1'b0;
        dump_base = '0;
        dump_len = '0;
        out_ready = 1'b0;
        step();
        step();
        chk_reset_outputs("reset");
        reset = 1'b0;
        step();
        chk("idle_state", state, 0);
        chk("idle_in_ready", in_ready, 0);

        words = '{16'd10, 16'd20, 16'd30, 16'd40};
        run_session(4, 0, 4, 0, 1'b0);

        fill_random(10);
        run_session(10, 6, 4, 0, 1'b0);

        fill_random(5);
        run_session(5, 3, 6, 1, 1'b0);

        fill_random(3);
        run_session(3, 1, 0, 0, 1'b0);

        fill_random(8);
        run_session(8, 5, 8, 2, 1'b0);

        fill_random(10);
        run_session(10, 2, 6, 0, 1'b1);

        fill_random(4);
        run_session(4, 7, 5, 2, 1'b0);

        for (int s = 0; s < 4; s++) begin
            fill_random($urandom_range(1, 12));
            run_session(words.size(), $urandom_range(0, 7), $urandom_range(0, 8),
                        $urandom_range(0, 2), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_stream_port.md
# mem_stream_port

Parametrised host stream port that replaces the fixed 16-bit, file-paced load/dump handshake around the processor top. It accepts a word stream from the host into data memory, starts the cores, waits for completion, then streams a programmable memory window back out. Both directions use valid/ready flow control. It sits between the host/testbench interface and the shared data-memory write/read port of `main`.

## Interface
- `DATA_W`, 16, memory word and stream width
- `ADDR_W`, 8, memory address width; depth is 2**ADDR_W words
- `clk`  in  1  system clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high; one clock domain only
- `load_start`  in  1  one-cycle pulse; begins a session from IDLE
- `in_data`  in  DATA_W  host word
- `in_valid`  in  1  host word valid
- `in_last`  in  1  marks the final load word
- `in_ready`  out  1  port accepts a word
- `mem_we`  out  1  memory write enable
- `mem_addr`  out  ADDR_W  memory address (write or read)
- `mem_wdata`  out  DATA_W  write data
- `mem_rdata`  in  DATA_W  read data, valid 1 cycle after address
- `core_start`  out  1  one-cycle pulse to cores
- `core_done`  in  1  level or pulse; cores finished
- `dump_base`  in  ADDR_W  first dump address, sampled on DUMP entry
- `dump_len`  in  ADDR_W+1  words to dump, sampled on DUMP entry, 0..2**ADDR_W
- `out_data`  out  DATA_W  dump word
- `out_valid`  out  1  dump word valid
- `out_last`  out  1  final dump word
- `out_ready`  in  1  host accepts dump word
- `state`  out  2  IDLE=0, LOAD=1, RUN=2, DUMP=3
- `session_done`  out  1  one-cycle pulse on return to IDLE
- `load_overflow`  out  1  sticky; load exceeded depth

## Operation
- Reset: state IDLE; every output 0 (`in_ready`, `mem_we`, `mem_addr`, `mem_wdata`, `core_start`, `out_*`, `session_done`, `load_overflow`); counters 0; skid buffer emptied.
- IDLE: `in_ready`=0. `load_start` → LOAD; clears `load_overflow` and the write counter.
- LOAD: `in_ready`=1. Each accepted word (`in_valid`&`in_ready`) is written to address = write count, then the count increments.
- Overflow: after 2**ADDR_W words without `in_last`, further words are still accepted but not written (`mem_we`=0), and `load_overflow` is set. The counter saturates and does not wrap.
- An accepted `in_last` moves the block to RUN in the next cycle, including when that word is itself dropped.
- RUN: `core_start` pulses for the first cycle only. `in_ready`=0. `core_done` sampled high moves the block to DUMP. A `core_done` already high in the `core_start` cycle is honoured.
- DUMP: latch base/len. Issue reads at base, base+1, … modulo 2**ADDR_W (wrap permitted), len reads total. Read data enters a 2-entry skid buffer. A read is issued only if the buffer has room for the in-flight word, so no data is lost under any `out_ready` pattern.
- `out_last` is high with the len-th word. Its handshake moves the block to IDLE and pulses `session_done`.
- `dump_len`=0: DUMP lasts one cycle, `out_valid` never rises, then IDLE with `session_done`.
- `load_start` outside IDLE is ignored. `reset` in any state aborts immediately to the reset values.

## Timing
- Write: handshake at cycle N → `mem_we`/`mem_addr`/`mem_wdata` registered, high at N+1.
- LOAD→RUN: `in_last` accepted at N → state=RUN and `core_start`=1 at N+1.
- RUN→DUMP: `core_done` at N → state=DUMP at N+1. First read address at N+1, first `out_valid` at N+3.
- With `out_ready` held high, throughput is one word per cycle after the first.
- `out_data` holds stable while `out_valid`&!`out_ready`.

## Structure
- Shared package/definitions: state encodings (IDLE/LOAD/RUN/DUMP), default `DATA_W`/`ADDR_W`.
- Sub-module `stream_skid`: 2-entry valid/ready buffer with `count` output, parametrised by `DATA_W`.
- Top contains the FSM, write counter, read address/remaining counters and in-flight flag.

## Test plan
- Load 4 words (10,20,30,40, last on 40) with `dump_base`=0, `dump_len`=4, `out_ready`=1 → memory writes at addr 0..3; one `core_start` pulse; outputs 10,20,30,40 with `out_last` on 40; `session_done` pulse.
- Dump with `out_ready` toggling 1,0,0,1 and random stalls, len=6 → no drops or duplicates; `out_data` stable while stalled.
- `ADDR_W`=3, dump_base=6, len=4 → reads addresses 6,7,0,1.
- `ADDR_W`=3, load 10 words → only the first 8 are written; `load_overflow`=1; block proceeds to RUN.
- `dump_len`=0 → no `out_valid`; return to IDLE with `session_done`.
- `reset` asserted mid-DUMP with `out_valid` high → next cycle state=0, all outputs 0; new `load_start` runs a clean session.
